leds_pwm_wb: RTL and testbench

Parametrised Wishbone LED controller, successor to the 4-bit on/off LED register. Drives NUM_LEDS outputs, each with an 8-bit (PWM_WIDTH) brightness duty, a shared on/off mask, and a global blink mode from a programmable prescaler. Sits on the GPMC-to-Wishbone bus as a slave beside the other peripheral blocks.

---
 rtl/leds_pwm_pkg.sv | 52 +++++
 rtl/leds_pwm_wb_channel.sv | 51 +++++
 rtl/leds_pwm_wb.sv | 158 +++++++++++++++
 tb/tb_leds_pwm_wb.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/leds_pwm_pkg.sv
// ---------------------------------------------------------------------------
// leds_pwm_pkg
// Shared definitions for the Wishbone PWM LED controller: register word
// addresses, CTRL bit positions, the register-select encoding and the
// address decoder used by the bus slave.
// ---------------------------------------------------------------------------
package leds_pwm_pkg;

   // Register word addresses
   localparam int unsigned ADDR_CTRL      = 32'd0;
   localparam int unsigned ADDR_MASK      = 32'd1;
   localparam int unsigned ADDR_BLINK     = 32'd2;
   localparam int unsigned ADDR_STATUS    = 32'd3;
   localparam int unsigned ADDR_DUTY_BASE = 32'd4;

   // CTRL register layout
   localparam int unsigned CTRL_ENABLE_BIT = 32'd0;
   localparam int unsigned CTRL_BLINK_BIT  = 32'd1;
   localparam int unsigned CTRL_WIDTH      = 32'd2;

   // Which register a bus address selects
   typedef enum logic [2:0] {
      SEL_NONE   = 3'd0,
      SEL_CTRL   = 3'd1,
      SEL_MASK   = 3'd2,
      SEL_BLINK  = 3'd3,
      SEL_STATUS = 3'd4,
      SEL_DUTY   = 3'd5
   } reg_sel_e;

   // Map a word address onto a register; DUTY slots past the last channel
   // and anything beyond the map decode as SEL_NONE.
   function automatic reg_sel_e decode_reg(input int unsigned addr,
                                           input int unsigned num_leds);
      reg_sel_e sel;
      if (addr == ADDR_CTRL) begin
         sel = SEL_CTRL;
      end else if (addr == ADDR_MASK) begin
         sel = SEL_MASK;
      end else if (addr == ADDR_BLINK) begin
         sel = SEL_BLINK;
      end else if (addr == ADDR_STATUS) begin
         sel = SEL_STATUS;
      end else if ((addr >= ADDR_DUTY_BASE) && (addr < (ADDR_DUTY_BASE + num_leds))) begin
         sel = SEL_DUTY;
      end else begin
         sel = SEL_NONE;
      end
      return sel;
   endfunction

endpackage

// File: rtl/leds_pwm_wb_channel.sv
// ---------------------------------------------------------------------------
// led_pwm_channel
// One LED channel: compares the shared PWM counter against this channel's
// duty and gates the result with enable and blink phase. Output registered.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-low reset
//   duty       channel duty (all-ones = always on, zero = always off)
//   pwm_cnt    shared free-running PWM counter
//   enable     global enable AND per-LED mask bit
//   blink_gate blink phase, or 1 when blinking is disabled
//   led        registered LED drive
// ---------------------------------------------------------------------------
module led_pwm_channel #(
   parameter int unsigned PWM_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [PWM_WIDTH-1:0] duty,
   input  logic [PWM_WIDTH-1:0] pwm_cnt,
   input  logic                 enable,
   input  logic                 blink_gate,
   output logic                 led
);

   logic pwm_on_s;
   logic led_r;

   // Duty compare; the all-ones case is forced on so full duty has no gap
   always_comb begin
      pwm_on_s = 1'b0;
      if (duty == {PWM_WIDTH{1'b1}}) begin
         pwm_on_s = 1'b1;
      end else begin
         pwm_on_s = (pwm_cnt < duty);
      end
   end

   // LED output register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         led_r <= 1'b0;
      end else begin
         led_r <= enable & pwm_on_s & blink_gate;
      end
   end

   assign led = led_r;

endmodule

// File: rtl/leds_pwm_wb.sv
// ---------------------------------------------------------------------------
// leds_pwm_wb
// Wishbone slave LED controller: NUM_LEDS PWM channels with per-channel
// duty, shared on/off mask, global enable and prescaled blink mode.
//
// Ports:
//   clk            system clock
//   reset          asynchronous active-low reset
//   led            registered LED drive, one bit per channel
//   wbs_address    word address
//   wbs_writedata  write data
//   wbs_readdata   registered read data, held until the next read
//   wbs_write      1 = write, 0 = read
//   wbs_cycle      bus cycle in progress
//   wbs_ack        one-cycle acknowledge, the cycle after acceptance
// ---------------------------------------------------------------------------
module leds_pwm_wb
   import leds_pwm_pkg::*;
#(
   parameter int unsigned NUM_LEDS   = 4,
   parameter int unsigned PWM_WIDTH  = 8,
   parameter int unsigned DATA_WIDTH = 16,
   parameter int unsigned ADDR_WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [NUM_LEDS-1:0]   led,
   input  logic [ADDR_WIDTH-1:0] wbs_address,
   input  logic [DATA_WIDTH-1:0] wbs_writedata,
   output logic [DATA_WIDTH-1:0] wbs_readdata,
   input  logic                  wbs_write,
   input  logic                  wbs_cycle,
   output logic                  wbs_ack
);

   localparam int unsigned IDX_W = (NUM_LEDS > 32'd1) ? $clog2(NUM_LEDS) : 32'd1;

   logic [CTRL_WIDTH-1:0] ctrl_r;
   logic [NUM_LEDS-1:0]   mask_r;
   logic [DATA_WIDTH-1:0] blink_r;
   logic [PWM_WIDTH-1:0]  duty_r [NUM_LEDS];
   logic [PWM_WIDTH-1:0]  pwm_cnt_r;
   logic [DATA_WIDTH-1:0] presc_r;
   logic                  blink_phase_r;
   logic                  ack_r;
   logic [DATA_WIDTH-1:0] readdata_r;

   logic                  accept_s;
   reg_sel_e              sel_s;
   logic [IDX_W-1:0]      duty_idx_s;
   logic [DATA_WIDTH-1:0] rdata_s;
   logic                  blink_gate_s;

   // A new access is taken only while no ack is outstanding, so back-to-back
   // cycles alternate accept/ack.
   assign accept_s   = wbs_cycle & ~ack_r;
   assign sel_s      = decode_reg(32'(wbs_address), NUM_LEDS);
   assign duty_idx_s = IDX_W'(wbs_address - ADDR_WIDTH'(ADDR_DUTY_BASE));

   // Read data mux; unmapped addresses read as zero
   always_comb begin
      rdata_s = {DATA_WIDTH{1'b0}};
      case (sel_s)
         SEL_CTRL:   rdata_s[CTRL_WIDTH-1:0] = ctrl_r;
         SEL_MASK:   rdata_s[NUM_LEDS-1:0]   = mask_r;
         SEL_BLINK:  rdata_s                 = blink_r;
         SEL_STATUS: begin
            rdata_s[0]           = blink_phase_r;
            rdata_s[PWM_WIDTH:1] = pwm_cnt_r;
         end
         SEL_DUTY:   rdata_s[PWM_WIDTH-1:0]  = duty_r[duty_idx_s];
         default:    rdata_s                 = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Bus acknowledge and read data capture
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ack_r      <= 1'b0;
         readdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         ack_r <= accept_s;
         if (accept_s && !wbs_write) begin
            readdata_r <= rdata_s;
         end
      end
   end

   // Writable register file; STATUS and unmapped writes fall to default
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl_r  <= {CTRL_WIDTH{1'b0}};
         mask_r  <= {NUM_LEDS{1'b0}};
         blink_r <= {DATA_WIDTH{1'b0}};
         for (int i = 0; i < int'(NUM_LEDS); i++) begin
            duty_r[i] <= {PWM_WIDTH{1'b0}};
         end
      end else if (accept_s && wbs_write) begin
         case (sel_s)
            SEL_CTRL:  ctrl_r               <= wbs_writedata[CTRL_WIDTH-1:0];
            SEL_MASK:  mask_r               <= wbs_writedata[NUM_LEDS-1:0];
            SEL_BLINK: blink_r              <= wbs_writedata;
            SEL_DUTY:  duty_r[duty_idx_s]   <= wbs_writedata[PWM_WIDTH-1:0];
            default:   ctrl_r               <= ctrl_r;
         endcase
      end
   end

   // Free-running PWM counter, wraps naturally
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pwm_cnt_r <= {PWM_WIDTH{1'b0}};
      end else begin
         pwm_cnt_r <= pwm_cnt_r + {{(PWM_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // Blink prescaler: reload BLINK and toggle phase when the count hits zero.
   // A new BLINK value only takes effect at the next reload.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc_r       <= {DATA_WIDTH{1'b0}};
         blink_phase_r <= 1'b1;
      end else if (blink_r == {DATA_WIDTH{1'b0}}) begin
         presc_r       <= {DATA_WIDTH{1'b0}};
         blink_phase_r <= 1'b1;
      end else if (presc_r == {DATA_WIDTH{1'b0}}) begin
         presc_r       <= blink_r;
         blink_phase_r <= ~blink_phase_r;
      end else begin
         presc_r       <= presc_r - {{(DATA_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   // With blink mode off the phase must not gate the LEDs
   assign blink_gate_s = blink_phase_r | ~ctrl_r[CTRL_BLINK_BIT];

   genvar g;
   generate
      for (g = 0; g < int'(NUM_LEDS); g++) begin : g_chan
         led_pwm_channel #(
            .PWM_WIDTH (PWM_WIDTH)
         ) u_chan (
            .clk        (clk),
            .reset      (reset),
            .duty       (duty_r[g]),
            .pwm_cnt    (pwm_cnt_r),
            .enable     (ctrl_r[CTRL_ENABLE_BIT] & mask_r[g]),
            .blink_gate (blink_gate_s),
            .led        (led[g])
         );
      end
   endgenerate

   assign wbs_ack      = ack_r;
   assign wbs_readdata = readdata_r;

endmodule

// File: tb/tb_leds_pwm_wb.sv
// ---------------------------------------------------------------------------
// tb_leds_pwm_wb
// Self-checking bench for leds_pwm_wb. Read expectations are queued when a
// read is driven and popped when the ack arrives.
// ---------------------------------------------------------------------------
module tb_leds_pwm_wb;

   logic        clk;
   logic        reset;
   logic [3:0]  led;
   logic [3:0]  wbs_address;
   logic [15:0] wbs_writedata;
   logic [15:0] wbs_readdata;
   logic        wbs_write;
   logic        wbs_cycle;
   logic        wbs_ack;

   int n_checks = 0;
   int n_errors = 0;

   logic [15:0] exp_q[$];
   logic [7:0]  m_cnt;

   leds_pwm_wb dut (
      .clk           (clk),
      .reset         (reset),
      .led           (led),
      .wbs_address   (wbs_address),
      .wbs_writedata (wbs_writedata),
      .wbs_readdata  (wbs_readdata),
      .wbs_write     (wbs_write),
      .wbs_cycle     (wbs_cycle),
      .wbs_ack       (wbs_ack)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference PWM counter: counts every clock since reset release
   always @(posedge clk or negedge reset) begin
      if (!reset) m_cnt <= 8'd0;
      else        m_cnt <= m_cnt + 8'd1;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One bus access; for reads the expected data is queued at drive time
   task automatic wb_access(input logic we, input logic [3:0] addr,
                            input logic [15:0] data, input logic [15:0] exp_rd,
                            input logic is_status);
      logic [15:0] exp_v;
      @(negedge clk);
      check_eq("ack_idle", wbs_ack, 1'b0);
      wbs_cycle     = 1'b1;
      wbs_write     = we;
      wbs_address   = addr;
      wbs_writedata = data;
      if (!we) begin
         if (is_status) exp_q.push_back({7'd0, m_cnt, 1'b1});
         else           exp_q.push_back(exp_rd);
      end
      @(posedge clk); #1;
      check_eq("ack_pulse", wbs_ack, 1'b1);
      if (!we) begin
         exp_v = exp_q.pop_front();
         check_eq($sformatf("rd_addr%0d", addr), wbs_readdata, exp_v);
      end
      @(negedge clk);
      wbs_cycle = 1'b0;
      wbs_write = 1'b0;
      @(posedge clk); #1;
      check_eq("ack_single", wbs_ack, 1'b0);
   endtask

   task automatic wr(input logic [3:0] addr, input logic [15:0] data);
      wb_access(1'b1, addr, data, 16'h0000, 1'b0);
   endtask

   task automatic rd(input logic [3:0] addr, input logic [15:0] exp_rd);
      wb_access(1'b0, addr, 16'h0000, exp_rd, 1'b0);
   endtask

   task automatic rd_status();
      wb_access(1'b0, 4'd3, 16'h0000, 16'h0000, 1'b1);
   endtask

   // Count high cycles of every LED over one full PWM period
   task automatic count_period(output int cnt [4]);
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      repeat (256) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) if (led[i] === 1'b1) cnt[i]++;
      end
   endtask

   initial begin
      int cnt [4];
      int last_t;
      int n_trans;
      logic prev;

      reset         = 1'b0;
      wbs_cycle     = 1'b0;
      wbs_write     = 1'b0;
      wbs_address   = 4'd0;
      wbs_writedata = 16'h0000;
      repeat (3) @(negedge clk);
      check_eq("rst_led", led, 4'h0);
      check_eq("rst_ack", wbs_ack, 1'b0);
      check_eq("rst_rdata", wbs_readdata, 16'h0000);
      reset = 1'b1;

      // Reset values
      rd(4'd0, 16'h0000);
      rd(4'd1, 16'h0000);
      rd(4'd2, 16'h0000);
      rd_status();
      for (int a = 4; a < 8; a++) rd(4'(a), 16'h0000);

      // Register read/write
      wr(4'd6, 16'h0040);
      wr(4'd1, 16'h000F);
      wr(4'd0, 16'h0001);
      rd(4'd6, 16'h0040);
      rd(4'd1, 16'h000F);
      rd(4'd0, 16'h0001);

      // PWM duty
      wr(4'd4, 16'h0040);
      wr(4'd5, 16'h0000);
      wr(4'd7, 16'h00FF);
      repeat (3) @(negedge clk);
      count_period(cnt);
      check_eq("pwm_led0", cnt[0], 64);
      check_eq("pwm_led1", cnt[1], 0);
      check_eq("pwm_led2", cnt[2], 64);
      check_eq("pwm_led3", cnt[3], 256);

      // Global enable off blanks everything
      wr(4'd0, 16'h0000);
      repeat (3) @(negedge clk);
      count_period(cnt);
      check_eq("dis_led0", cnt[0], 0);
      check_eq("dis_led3", cnt[3], 0);

      // Blink mode, half-period BLINK+1 = 10 cycles
      wr(4'd4, 16'h00FF);
      wr(4'd2, 16'h0009);
      wr(4'd0, 16'h0003);
      rd(4'd2, 16'h0009);
      @(negedge clk);
      prev    = led[0];
      last_t  = -1;
      n_trans = 0;
      for (int t = 1; t < 100; t++) begin
         @(negedge clk);
         if (led[0] !== prev) begin
            if (last_t >= 0) check_eq("blink_half", t - last_t, 10);
            last_t = t;
            n_trans++;
            prev = led[0];
         end
      end
      check_eq("blink_toggles", (n_trans >= 8), 1'b1);

      // BLINK=0 -> phase forced high, LED steady
      wr(4'd2, 16'h0000);
      repeat (3) @(negedge clk);
      cnt[0] = 0;
      repeat (30) begin
         @(negedge clk);
         if (led[0] === 1'b1) cnt[0]++;
      end
      check_eq("blink_off_steady", cnt[0], 30);
      rd_status();

      // Unmapped / read-only writes are acked and ignored
      wr(4'd15, 16'hFFFF);
      wr(4'd3,  16'hFFFF);
      wr(4'd8,  16'hFFFF);
      rd(4'd15, 16'h0000);
      rd(4'd8,  16'h0000);
      rd(4'd0,  16'h0003);
      rd(4'd1,  16'h000F);
      rd(4'd2,  16'h0000);
      rd(4'd4,  16'h00FF);
      rd(4'd5,  16'h0000);
      rd(4'd6,  16'h0040);
      rd(4'd7,  16'h00FF);
      rd_status();

      // Unused register bits are not stored
      wr(4'd0, 16'hFFFD);
      wr(4'd1, 16'hFFF5);
      rd(4'd0, 16'h0001);
      rd(4'd1, 16'h0005);
      wr(4'd1, 16'h000F);

      // Reset in the middle of an ack cycle
      repeat (3) @(negedge clk);
      check_eq("pre_rst_led3", led[3], 1'b1);
      @(negedge clk);
      wbs_cycle   = 1'b1;
      wbs_write   = 1'b0;
      wbs_address = 4'd7;
      @(posedge clk); #1;
      check_eq("mid_ack", wbs_ack, 1'b1);
      reset = 1'b0;
      #1;
      check_eq("mid_rst_led", led, 4'h0);
      check_eq("mid_rst_ack", wbs_ack, 1'b0);
      check_eq("mid_rst_rdata", wbs_readdata, 16'h0000);
      @(negedge clk);
      wbs_cycle = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         check_eq("post_rst_ack", wbs_ack, 1'b0);
      end
      rd(4'd0, 16'h0000);
      rd(4'd1, 16'h0000);
      rd(4'd2, 16'h0000);
      rd(4'd7, 16'h0000);
      rd_status();
      check_eq("post_rst_led", led, 4'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
